// File: rtl/mc_a_burst_seq_pkg.sv
// mc_a_pkg: shared widths and sequencer states for the MemA burst sequencer
package mc_a_pkg;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, FILL, SKIP, DRAIN} seqStateT;
endpackage

// File: rtl/mc_a_burst_seq_if.sv
// mc_a_burst_seq_if: fill stream, drain stream and MemA pin bundle of the burst sequencer
interface mc_a_burst_seq_if;
    import mc_a_pkg::*;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          IncA;
    logic          WEA;
    logic [DW-1:0] DataInA;
    logic [DW-1:0] DOut1;
    logic [AW-1:0] AddrA;
    modport master (
        input  in_valid, in_data, out_ready, DOut1, AddrA,
        output in_ready, out_valid, out_data, IncA, WEA, DataInA
    );
    modport slave (
        output in_valid, in_data, out_ready, DOut1, AddrA,
        input  in_ready, out_valid, out_data, IncA, WEA, DataInA
    );
endinterface

// File: rtl/mc_a_burst_seq.sv
// mc_a_burst_seq: burst fill/drain sequencer in front of the auto-increment MemA memory
module mc_a_burst_seq
    import mc_a_pkg::*;
(
    input  logic            clock,
    input  logic            Reset,
    input  logic            start_fill,
    input  logic [AW:0]     fill_len,
    input  logic            start_drain,
    mc_a_burst_seq_if.master bus,
    output logic [AW:0]     level,
    output logic            busy,
    output logic            done,
    output logic            sync_err
);
    localparam logic [AW:0]   MaxLen = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LenOne = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    seqStateT      state, stateNext;
    logic [AW-1:0] ptr, ptrNext, base, baseNext, skipCnt, skipNext;
    logic [AW:0]   rem, remNext, fillLen, lenNext, levelR, levelNext;
    logic          incR, incNext, weR, weNext;
    logic [DW-1:0] dinR, dinNext, outDataR, odNext;
    logic          outValidR, ovNext, rdIss, rdIssNext, rdPend, rdPendNext;
    logic          doneR, doneNext, chk, chkNext, syncErrR, errNext;
    logic [AW-1:0] ptrNow, skipNow;
    logic [AW:0]   lenClamp;
    logic          accept, take, issueRd;

    // The memory pointer moves on the edge that consumes a registered IncA,
    // so ptrNow is where the pointer will be once any in-flight access lands.
    assign ptrNow   = ptr + AW'(incR);
    assign skipNow  = base - ptrNow;
    assign lenClamp = (fill_len > MaxLen) ? MaxLen : fill_len;
    assign accept   = bus.in_valid && bus.in_ready;
    assign take     = bus.out_valid && bus.out_ready;
    assign issueRd  = (state == DRAIN) && !rdIss && !rdPend && !outValidR;

    assign bus.in_ready  = (state == FILL) && (rem != '0);
    assign bus.out_valid = outValidR;
    assign bus.out_data  = outDataR;
    assign bus.IncA      = incR;
    assign bus.WEA       = weR;
    assign bus.DataInA   = dinR;
    assign level         = levelR;
    assign busy          = state != IDLE;
    assign done          = doneR;
    assign sync_err      = syncErrR;

    // Next-state and registered-output decisions; memory pins default to idle re-read
    always_comb begin
        stateNext  = state;
        ptrNext    = ptrNow;
        baseNext   = base;
        remNext    = rem;
        skipNext   = skipCnt;
        lenNext    = fillLen;
        levelNext  = levelR;
        incNext    = 1'b0;
        weNext     = 1'b0;
        dinNext    = dinR;
        ovNext     = rdPend ? 1'b1 : outValidR;
        odNext     = rdPend ? bus.DOut1 : outDataR;
        rdIssNext  = 1'b0;
        rdPendNext = rdIss;
        doneNext   = 1'b0;
        chkNext    = incR;
        errNext    = syncErrR | (chk && busy && (bus.AddrA != ptr));
        case (state)
            IDLE: begin
                if (start_fill && lenClamp != '0) begin
                    stateNext = FILL;
                    baseNext  = ptrNow;
                    remNext   = lenClamp;
                    lenNext   = lenClamp;
                end else if (start_drain && levelR != '0) begin
                    stateNext = (skipNow == '0) ? DRAIN : SKIP;
                    skipNext  = skipNow;
                    remNext   = levelR;
                end
            end
            FILL: begin
                if (accept) begin
                    incNext = 1'b1;
                    weNext  = 1'b1;
                    dinNext = bus.in_data;
                    remNext = rem - LenOne;
                    if (rem == LenOne) begin
                        stateNext = IDLE;
                        levelNext = fillLen;
                        doneNext  = 1'b1;
                    end
                end
            end
            SKIP: begin
                incNext  = 1'b1;
                skipNext = skipCnt - PtrOne;
                if (skipCnt == PtrOne) stateNext = DRAIN;
            end
            DRAIN: begin
                if (issueRd) begin
                    incNext   = 1'b1;
                    rdIssNext = 1'b1;
                end
                if (take) begin
                    ovNext  = 1'b0;
                    remNext = rem - LenOne;
                    if (rem == LenOne) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            base      <= '0;
            rem       <= '0;
            skipCnt   <= '0;
            fillLen   <= '0;
            levelR    <= '0;
            incR      <= 1'b0;
            weR       <= 1'b0;
            dinR      <= '0;
            outValidR <= 1'b0;
            outDataR  <= '0;
            rdIss     <= 1'b0;
            rdPend    <= 1'b0;
            doneR     <= 1'b0;
            chk       <= 1'b0;
            syncErrR  <= 1'b0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            base      <= baseNext;
            rem       <= remNext;
            skipCnt   <= skipNext;
            fillLen   <= lenNext;
            levelR    <= levelNext;
            incR      <= incNext;
            weR       <= weNext;
            dinR      <= dinNext;
            outValidR <= ovNext;
            outDataR  <= odNext;
            rdIss     <= rdIssNext;
            rdPend    <= rdPendNext;
            doneR     <= doneNext;
            chk       <= chkNext;
            syncErrR  <= errNext;
        end
    end
endmodule

// File: tb/tb_mc_a_burst_seq.sv
// tb_mc_a_burst_seq: randomized fill/drain bursts against a MemA model and a queue-level reference
module tb_mc_a_burst_seq;
    import mc_a_pkg::*;

    logic          clock = 1'b0;
    logic          Reset = 1'b0;
    logic          start_fill = 1'b0;
    logic          start_drain = 1'b0;
    logic [AW:0]   fill_len = '0;
    logic [AW:0]   level;
    logic          busy, done, sync_err;

    mc_a_burst_seq_if bus();

    mc_a_burst_seq dut (
        .clock(clock), .Reset(Reset), .start_fill(start_fill), .fill_len(fill_len),
        .start_drain(start_drain), .bus(bus), .level(level), .busy(busy),
        .done(done), .sync_err(sync_err)
    );

    always #5 clock = ~clock;

    // MemA behavioural model; skew perturbs the reported address only
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] memPtr = '0;
    logic [AW-1:0] skew = '0;
    logic [DW-1:0] dout = '0;
    assign bus.DOut1 = dout;
    assign bus.AddrA = memPtr + skew;

    always @(posedge clock) begin
        if (!Reset) begin
            memPtr <= '0;
            dout   <= '0;
        end else begin
            if (bus.IncA && bus.WEA) mem[memPtr] <= bus.DataInA;
            if (!bus.WEA) dout <= mem[memPtr];
            if (bus.IncA) memPtr <= memPtr + AW'(1);
        end
    end

    // Event counters, sampled just after each edge
    int doneCnt = 0, incCnt = 0, weBad = 0;
    always @(posedge clock) begin
        #1;
        if (done) doneCnt++;
        if (bus.IncA) incCnt++;
        if (bus.WEA && !bus.IncA) weBad++;
    end

    int checks = 0, passes = 0;
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: bytes of the last fill, where they start, and the memory pointer
    int mLevel = 0, mBase = 0, mPtr = 0;
    bit syncExp = 0;
    logic [DW-1:0] mData[$];
    logic [DW-1:0] pend[$];

    task automatic randPend(input int n);
        pend.delete();
        for (int i = 0; i < n; i++) pend.push_back(DW'($urandom));
    endtask

    task automatic doReset(input int n);
        @(negedge clock);
        Reset = 1'b0;
        repeat (n) @(negedge clock);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_level", level, 0);
        checkVal("rst_out_valid", bus.out_valid, 0);
        checkVal("rst_inc", bus.IncA, 0);
        checkVal("rst_sync_err", sync_err, 0);
        Reset = 1'b1;
        mLevel = 0; mBase = 0; mPtr = 0; syncExp = 0;
        mData.delete();
    endtask

    task automatic doFill(input int len, input bit gaps, input bit withDrain);
        int L, idx, guard, d0, i0, bad;
        L = (len > DEPTH) ? DEPTH : len;
        d0 = doneCnt; i0 = incCnt;
        @(negedge clock);
        start_fill = 1'b1; fill_len = (AW+1)'(len); start_drain = withDrain;
        @(negedge clock);
        start_fill = 1'b0; start_drain = 1'b0;
        if (L == 0) begin
            repeat (3) @(negedge clock);
            checkVal("fill0_busy", busy, 0);
            checkVal("fill0_done", doneCnt - d0, 0);
            checkVal("fill0_level", level, mLevel);
            return;
        end
        checkVal("fill_busy", busy, 1);
        idx = 0; guard = 0;
        while (busy && guard < 200) begin
            if (idx < L) begin
                bus.in_valid = !gaps || ($urandom_range(0, 2) != 0);
                bus.in_data = pend[idx];
            end else bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) idx++;
            guard++;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        checkVal("fill_timeout", guard < 200, 1);
        checkVal("fill_level", level, L);
        checkVal("fill_done", doneCnt - d0, 1);
        checkVal("fill_inc", incCnt - i0, L);
        bad = 0;
        for (int i = 0; i < L; i++) if (mem[(mPtr + i) % DEPTH] !== pend[i]) bad++;
        checkVal("fill_mem", bad, 0);
        mBase = mPtr;
        mPtr = (mPtr + L) % DEPTH;
        mLevel = L;
        mData.delete();
        for (int i = 0; i < L; i++) mData.push_back(pend[i]);
        checkVal("fill_ptr", memPtr, mPtr);
    endtask

    task automatic doDrain(input int stallPct, input int forceStall, input int resetAfter);
        int d0, i0, skip, guard, stallLeft, bad;
        bit prevStall;
        logic [DW-1:0] prevData;
        logic [DW-1:0] got[$];
        skip = (mBase - mPtr) & (DEPTH - 1);
        d0 = doneCnt; i0 = incCnt;
        @(negedge clock);
        start_drain = 1'b1;
        @(negedge clock);
        start_drain = 1'b0;
        if (mLevel == 0) begin
            repeat (3) @(negedge clock);
            checkVal("drain0_busy", busy, 0);
            checkVal("drain0_done", doneCnt - d0, 0);
            return;
        end
        checkVal("drain_busy", busy, 1);
        stallLeft = forceStall; prevStall = 0; prevData = '0; guard = 0;
        while (busy && guard < 400) begin
            if (prevStall) begin
                checkVal("hold_valid", bus.out_valid, 1);
                checkVal("hold_data", bus.out_data, prevData);
            end
            if (stallLeft > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stallLeft--;
            end else bus.out_ready = $urandom_range(0, 99) >= stallPct;
            prevStall = bus.out_valid && !bus.out_ready;
            prevData = bus.out_data;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            guard++;
            @(negedge clock);
            if (resetAfter != 0 && got.size() == resetAfter) break;
        end
        bus.out_ready = 1'b0;
        checkVal("drain_timeout", guard < 400, 1);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (i >= mData.size() || got[i] !== mData[i]) bad++;
        checkVal("drain_data", bad, 0);
        if (resetAfter != 0) begin
            Reset = 1'b0;
            @(negedge clock);
            checkVal("midrst_busy", busy, 0);
            checkVal("midrst_level", level, 0);
            checkVal("midrst_out_valid", bus.out_valid, 0);
            checkVal("midrst_done", done, 0);
            Reset = 1'b1;
            mLevel = 0; mBase = 0; mPtr = 0; syncExp = 0;
            mData.delete();
            return;
        end
        checkVal("drain_count", got.size(), mLevel);
        checkVal("drain_done", doneCnt - d0, 1);
        checkVal("drain_inc", incCnt - i0, skip + mLevel);
        mPtr = (mBase + mLevel) % DEPTH;
        checkVal("drain_ptr", memPtr, mPtr);
        checkVal("drain_level", level, mLevel);
        checkVal("drain_out_valid", bus.out_valid, 0);
        checkVal("sync_err", sync_err, syncExp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        checkVal("init_busy", busy, 0);
        checkVal("init_inc", bus.IncA, 0);
        checkVal("init_wea", bus.WEA, 0);
        checkVal("init_din", bus.DataInA, 0);
        checkVal("init_in_ready", bus.in_ready, 0);
        checkVal("init_out_valid", bus.out_valid, 0);
        checkVal("init_out_data", bus.out_data, 0);
        checkVal("init_level", level, 0);
        checkVal("init_done", done, 0);
        checkVal("init_sync_err", sync_err, 0);
        Reset = 1'b1;

        pend.delete();
        pend.push_back(8'hA1); pend.push_back(8'hA2); pend.push_back(8'hA3);
        doFill(3, 0, 0);
        doDrain(0, 0, 0);

        randPend(3); doFill(3, 1, 0);
        doDrain(30, 5, 0);
        randPend(9); doFill(9, 1, 0);
        doDrain(40, 0, 0);
        randPend(4); doFill(4, 0, 1);
        doDrain(20, 0, 0);
        doFill(0, 0, 0);
        doDrain(0, 3, 0);

        repeat (8) begin
            n = $urandom_range(0, 9);
            randPend(n);
            doFill(n, 1, (n != 0) && ($urandom_range(0, 1) == 1));
            doDrain($urandom_range(0, 60), $urandom_range(0, 3), 0);
        end

        doReset(2);
        doDrain(0, 0, 0);
        randPend(5); doFill(5, 0, 0);
        doDrain(0, 0, 2);

        skew = AW'(1);
        randPend(5); doFill(5, 0, 0);
        skew = '0;
        syncExp = 1;
        checkVal("sync_set", sync_err, 1);
        randPend(2); doFill(2, 1, 0);
        doDrain(10, 0, 0);
        doReset(1);
        checkVal("we_without_inc", weBad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
